bit_count_asmd: RTL and testbench

//  Parametrised multi-mode bit counter built as a control FSM plus datapath (ASMD).

---
 rtl/bit_count_asmd.sv | 217 +++++++++++++++++++++
 tb/tb_bit_count_asmd.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_count_asmd.sv
// Multi-mode bit counter (ones / zeros / leading zeros / trailing zeros), one bit per clock.
// Control FSM (bit_count_ctrl) plus datapath (bit_count_dp), start/ready/done handshake.

module bit_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode_q,
  input  logic       a_is0,
  input  logic       a0,
  input  logic       left_is0,
  output logic       load,
  output logic       inc,
  output logic       shift,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   exit_cond;
  logic   count_bit;

  // Per-mode exit condition and "this bit counts" decision
  always_comb begin
    exit_cond = 1'b0;
    count_bit = 1'b0;
    case (mode_q)
      2'd0: begin
        exit_cond = a_is0 | left_is0;
        count_bit = a0;
      end
      2'd1: begin
        exit_cond = left_is0;
        count_bit = ~a0;
      end
      2'd2, 2'd3: begin
        exit_cond = left_is0 | a0;
        count_bit = ~a0;
      end
      default: begin
        exit_cond = 1'b1;
        count_bit = 1'b0;
      end
    endcase
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next = state;
    load       = 1'b0;
    inc        = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (exit_cond) begin
          state_next = DONE;
        end else begin
          shift      = 1'b1;
          inc        = count_bit;
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; status outputs registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

endmodule

module bit_count_dp #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             shift,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic [1:0]       mode_q,
  output logic             a_is0,
  output logic             a0,
  output logic             left_is0,
  output logic [CW-1:0]    result
);

  logic [WIDTH-1:0] a_reg;
  logic [CW-1:0]    left;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  assign a_is0    = (a_reg == {WIDTH{1'b0}});
  assign a0       = a_reg[0];
  assign left_is0 = (left == {CW{1'b0}});

  // Operand shifter, bit budget and result counter
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= {WIDTH{1'b0}};
      left   <= {CW{1'b0}};
      mode_q <= 2'd0;
      result <= {CW{1'b0}};
    end else if (load) begin
      // Leading-zero mode scans from the MSB, so present it at bit 0
      a_reg  <= (mode == 2'd2) ? bit_rev(a) : a;
      left   <= CW'(WIDTH);
      mode_q <= mode;
      result <= {CW{1'b0}};
    end else if (shift) begin
      a_reg  <= {1'b0, a_reg[WIDTH-1:1]};
      left   <= left - CW'(1);
      result <= inc ? (result + CW'(1)) : result;
    end else begin
      a_reg  <= a_reg;
      left   <= left;
      mode_q <= mode_q;
      result <= result;
    end
  end

endmodule

module bit_count_asmd #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    result
);

  logic       load;
  logic       inc;
  logic       shift;
  logic       a_is0;
  logic       a0;
  logic       left_is0;
  logic [1:0] mode_q;

  bit_count_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode_q   (mode_q),
    .a_is0    (a_is0),
    .a0       (a0),
    .left_is0 (left_is0),
    .load     (load),
    .inc      (inc),
    .shift    (shift),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  bit_count_dp #(.WIDTH(WIDTH), .CW(CW)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .inc      (inc),
    .shift    (shift),
    .mode     (mode),
    .a        (A),
    .mode_q   (mode_q),
    .a_is0    (a_is0),
    .a0       (a0),
    .left_is0 (left_is0),
    .result   (result)
  );

endmodule

// File: tb/tb_bit_count_asmd.sv
// Table-driven bench for bit_count_asmd: 8-bit and 16-bit instances, directed vectors
// with hand-computed results and done latencies, plus reset / busy / back-to-back sequences.

module tb_bit_count_asmd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [1:0]  mode8 = 2'd0, mode16 = 2'd0;
  logic [7:0]  a8 = 8'd0;
  logic [15:0] a16 = 16'd0;
  logic        ready8, busy8, done8, ready16, busy16, done16;
  logic [3:0]  result8;
  logic [4:0]  result16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_count_asmd #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .A(a8),
    .ready(ready8), .busy(busy8), .done(done8), .result(result8)
  );

  bit_count_asmd #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode16), .A(a16),
    .ready(ready16), .busy(busy16), .done(done16), .result(result16)
  );

  typedef struct {
    logic        w16;
    logic [1:0]  mode;
    logic [15:0] a;
    int          exp_result;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic w16, input logic st, input logic [1:0] m, input logic [15:0] a);
    if (w16) begin
      start16 = st; mode16 = m; a16 = a;
    end else begin
      start8 = st; mode8 = m; a8 = a[7:0];
    end
  endtask

  function automatic int get_ready(input logic w16);
    return w16 ? int'(ready16) : int'(ready8);
  endfunction
  function automatic int get_busy(input logic w16);
    return w16 ? int'(busy16) : int'(busy8);
  endfunction
  function automatic int get_done(input logic w16);
    return w16 ? int'(done16) : int'(done8);
  endfunction
  function automatic int get_result(input logic w16);
    return w16 ? int'(result16) : int'(result8);
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge E0 with start released.
  task automatic launch(input logic w16, input logic [1:0] m, input logic [15:0] a);
    int guard = 0;
    while (get_ready(w16) != 1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) check("ready_wait_timeout", 0, 1);
    drive(w16, 1'b1, m, a);
    @(posedge clk); #1;
    drive(w16, 1'b0, 2'd0, 16'd0);
  endtask

  // Edges after E0 until done is seen; -1 when the budget expires.
  task automatic wait_done(input logic w16, input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (get_done(w16) == 1) break;
      if (cyc >= budget) begin
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    launch(v.w16, v.mode, v.a);
    check($sformatf("v%0d_busy_after_accept", idx), get_busy(v.w16), 1);
    check($sformatf("v%0d_result_cleared", idx), get_result(v.w16), 0);
    wait_done(v.w16, 40, cyc);
    check($sformatf("v%0d_done_latency", idx), cyc, v.exp_lat);
    check($sformatf("v%0d_result", idx), get_result(v.w16), v.exp_result);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_one_cycle", idx), get_done(v.w16), 0);
    check($sformatf("v%0d_ready_after_done", idx), get_ready(v.w16), 1);
    check($sformatf("v%0d_result_held", idx), get_result(v.w16), v.exp_result);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    int pulses;

    vecs.push_back('{1'b0, 2'd0, 16'h00AA, 4, 9});
    vecs.push_back('{1'b0, 2'd0, 16'h0003, 2, 3});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 0, 1});
    vecs.push_back('{1'b0, 2'd1, 16'h000F, 4, 9});
    vecs.push_back('{1'b0, 2'd3, 16'h0028, 3, 4});
    vecs.push_back('{1'b0, 2'd2, 16'h0010, 3, 4});
    vecs.push_back('{1'b0, 2'd2, 16'h0000, 8, 9});
    vecs.push_back('{1'b0, 2'd3, 16'h0000, 8, 9});
    vecs.push_back('{1'b0, 2'd1, 16'h0000, 8, 9});
    vecs.push_back('{1'b0, 2'd0, 16'h00FF, 8, 9});
    vecs.push_back('{1'b0, 2'd1, 16'h00FF, 0, 9});
    vecs.push_back('{1'b0, 2'd3, 16'h0001, 0, 1});
    vecs.push_back('{1'b0, 2'd2, 16'h0080, 0, 1});
    vecs.push_back('{1'b0, 2'd2, 16'h0001, 7, 8});
    vecs.push_back('{1'b1, 2'd0, 16'hFFFF, 16, 17});
    vecs.push_back('{1'b1, 2'd1, 16'h0000, 16, 17});
    vecs.push_back('{1'b1, 2'd3, 16'h8000, 15, 16});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_ready8", int'(ready8), 1);
    check("reset_busy8", int'(busy8), 0);
    check("reset_done8", int'(done8), 0);
    check("reset_result8", int'(result8), 0);
    check("reset_ready16", int'(ready16), 1);
    check("reset_result16", int'(result16), 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset mid-RUN: ones, A=FF, reset sampled at E0+3
    launch(1'b0, 2'd0, 16'h00FF);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_ready", int'(ready8), 1);
    check("midrun_reset_busy", int'(busy8), 0);
    check("midrun_reset_result", int'(result8), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    check("midrun_reset_no_done", pulses, 0);

    // start pulsed while busy is ignored
    launch(1'b0, 2'd0, 16'h00FF);
    @(posedge clk); @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'd1, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'd0, 16'h0000);
    cyc = 3;
    pulses = 0;
    begin
      int more;
      wait_done(1'b0, 40, more);
      if (more > 0) begin
        cyc += more;
        pulses = 1;
      end else begin
        cyc = -1;
      end
    end
    check("busy_start_latency", cyc, 9);
    check("busy_start_result", int'(result8), 8);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    check("busy_start_one_done", pulses, 1);
    check("busy_start_result_kept", int'(result8), 8);

    // start held high across two operations
    drive(1'b0, 1'b1, 2'd0, 16'h0003);
    @(posedge clk); #1;
    a8 = 8'h07;
    wait_done(1'b0, 40, cyc);
    check("held_first_latency", cyc, 3);
    check("held_first_result", int'(result8), 2);
    @(posedge clk); #1;
    check("held_ready_between", int'(ready8), 1);
    @(posedge clk); #1;
    check("held_second_busy", int'(busy8), 1);
    check("held_second_cleared", int'(result8), 0);
    begin
      int more;
      wait_done(1'b0, 40, more);
      start8 = 1'b0;
      check("held_second_latency", more, 4);
    end
    check("held_second_result", int'(result8), 3);
    repeat (3) @(posedge clk);
    #1;
    check("held_end_idle", int'(ready8), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
